imem_loader: RTL and testbench
==============================

# imem_loader

Program loader for the instruction memory: the write side of the fetch path. It accepts a byte stream over a valid/ready handshake, assembles 16-bit instructions high byte first, and writes them into consecutive instruction-memory words starting at address 0. While loading it holds the processor in reset/stall via `cpu_hold`, then releases it and pulses `done`.

## Interface
- `ADDR_W`, 8: instruction-memory address width; maximum program length is 2**ADDR_W words.
- `DATA_W`, 16: instruction width; fixed at 2 bytes.
- `clk`  in  1  single system clock, rising edge.
- `rst_n`  in  1  reset, asynchronous and active-low.
- `load_start`  in  1  one-cycle request to begin a load; ignored unless idle.
- `load_len`  in  ADDR_W+1  word count, sampled with `load_start`; legal 0..2**ADDR_W.
- `abort`  in  1  synchronous cancel; returns to idle.
- `in_valid`  in  1  byte-stream valid.
- `in_data`  in  8  byte-stream data.
- `in_ready`  out  1  loader can accept a byte this cycle.
- `wr_en`  out  1  instruction-memory write strobe.
- `wr_addr`  out  ADDR_W  write address.
- `wr_data`  out  DATA_W  write data.
- `cpu_hold`  out  1  processor held; high whenever not IDLE.
- `busy`  out  1  same as `cpu_hold`, for the status register.
- `done`  out  1  one-cycle pulse at load completion.
- `err`  out  1  sticky checksum-mismatch flag.

## Operation
- States: IDLE, HI, LO, WRITE, CHK (only with the checksum build), DONE.
- IDLE: `load_start`=1 latches `load_len` into the word counter and clears `wr_addr` to 0 and `err` to 0. If `load_len`=0, go to CHK (or DONE without the checksum build). Otherwise go to HI.
- HI: `in_ready`=1. A byte is accepted when `in_valid && in_ready`; it is stored as `wr_data[15:8]`, then go to LO.
- LO: `in_ready`=1. On an accepted byte, store it as `wr_data[7:0]`, then go to WRITE.
- WRITE: `in_ready`=0 and `wr_en`=1 for exactly one cycle with the current `wr_addr`/`wr_data`. Next, `wr_addr`+1 and count-1. If the remaining count is 0, go to CHK (or DONE); otherwise go to HI.
- CHK: `in_ready`=1. Accept one checksum byte. If it is not equal to the XOR of all accepted data bytes, set `err`. Then go to DONE.
- DONE: `done`=1 for one cycle, then go to IDLE. `cpu_hold` drops in the IDLE cycle that follows.
- `load_len`=2**ADDR_W: the last write is at address 2**ADDR_W-1. `wr_addr` wraps to 0 afterwards, but no further write occurs.
- `abort` has priority over all handshakes and `load_start`. Next state is IDLE, with no write, no `done`, and `err` unchanged. Words already written stay written.
- `load_start` while busy: ignored; `load_len` is not resampled.
- `in_valid` with `in_ready`=0: byte not consumed; the source must hold it.

## Timing
- Reset values: `in_ready`=0, `wr_en`=0, `wr_addr`=0, `wr_data`=0, `cpu_hold`=0, `busy`=0, `done`=0, `err`=0. State is IDLE.
- Async reset mid-load: takes effect immediately, and all outputs go to their reset values.
- All outputs are registered or decoded from registered state. There is no combinational path from `in_valid` to `in_ready`.
- Back-to-back bytes: the minimum is 3 cycles per word (HI, LO, WRITE). `in_ready` is low every third cycle while streaming.
- `load_start` to first `in_ready`: 1 cycle.
- Last write to `done`: 1 cycle without the checksum build, or at least 2 cycles with it.

## Configuration
- `IMEM_LOADER_CHECKSUM_EN` defined: CHK state present. A running 8-bit XOR accumulator is cleared on `load_start`, and `err` reports the result of the comparison.
- `IMEM_LOADER_CHECKSUM_EN` undefined: no CHK state and no accumulator. The stream is exactly 2×`load_len` bytes, and `err` is tied to 0.

## Structure
- Shared package `imem_pkg` holds the following, which the fetch side and instruction memory also use:
  - opcode, ALU-op and branch-condition constants;
  - `ADDR_W`/`DATA_W` defaults;
  - the loader state enum.
- One sub-module, `imem_loader_csum`: the XOR accumulator and comparator. It is instantiated only under the macro.

## Test plan
- Reset, load_len=2, bytes 12 34 AB CD: writes [0]=1234, [1]=ABCD, one `wr_en` each. `done` pulses 1 cycle after the second write, and `cpu_hold` falls the following cycle.
- load_len=0: no `wr_en`, and `done` pulses within 2 cycles (checksum build: after one byte 00, with `err`=0).
- Checksum build, load_len=1, bytes 12 34, checksum 26: `err`=0. Repeat with checksum 27: `err`=1 and stays 1 until the next `load_start`.
- load_len=256 with a random `in_valid` gap pattern: 256 writes at addresses 0..255 in order, with data matching the stream. `in_ready` is never high in WRITE.
- `abort` asserted after the 3rd byte of a 4-word load:
  - only [0] is written;
  - IDLE is reached the next cycle, with no `done`;
  - a `load_start` raised during the load, before the abort, had no effect.
- Async `rst_n` pulse while in LO: all outputs are at reset values immediately, and a fresh load afterwards writes from address 0.

Source files
------------

// File: rtl/imem_pkg.sv
// Shared definitions for the instruction fetch path: ISA encodings, default
// memory geometry and the program-loader state encoding.
package imem_pkg;

  localparam int IMEM_ADDR_W = 8;
  localparam int IMEM_DATA_W = 16;

  localparam logic [3:0] OP_ALU  = 4'h0;
  localparam logic [3:0] OP_ALUI = 4'h1;
  localparam logic [3:0] OP_LD   = 4'h2;
  localparam logic [3:0] OP_ST   = 4'h3;
  localparam logic [3:0] OP_BR   = 4'h4;
  localparam logic [3:0] OP_JMP  = 4'h5;
  localparam logic [3:0] OP_LUI  = 4'h6;
  localparam logic [3:0] OP_HALT = 4'hF;

  localparam logic [2:0] ALU_ADD = 3'd0;
  localparam logic [2:0] ALU_SUB = 3'd1;
  localparam logic [2:0] ALU_AND = 3'd2;
  localparam logic [2:0] ALU_OR  = 3'd3;
  localparam logic [2:0] ALU_XOR = 3'd4;
  localparam logic [2:0] ALU_SHL = 3'd5;
  localparam logic [2:0] ALU_SHR = 3'd6;
  localparam logic [2:0] ALU_SLT = 3'd7;

  localparam logic [1:0] BR_EQ = 2'd0;
  localparam logic [1:0] BR_NE = 2'd1;
  localparam logic [1:0] BR_LT = 2'd2;
  localparam logic [1:0] BR_GE = 2'd3;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_HI    = 3'd1,
    ST_LO    = 3'd2,
    ST_WRITE = 3'd3,
    ST_CHK   = 3'd4,
    ST_DONE  = 3'd5
  } ldr_state_t;

  function automatic logic is_ctrl_op(input logic [3:0] op);
    return (op == OP_BR) || (op == OP_JMP);
  endfunction

endpackage

// File: rtl/imem_loader_csum.sv
// Running XOR over the accepted program bytes, compared against the trailing
// checksum byte. Present only in the IMEM_LOADER_CHECKSUM_EN build.
module imem_loader_csum
  import imem_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       clr,
  input  logic       data_vld,
  input  logic [7:0] data_byte,
  output logic       mismatch
);

  logic [7:0] acc;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc <= '0;
    end else if (clr) begin
      acc <= '0;
    end else if (data_vld) begin
      acc <= acc ^ data_byte;
    end
  end

  // Valid only while the loader is accepting the checksum byte.
  assign mismatch = (data_byte != acc);

endmodule

// File: rtl/imem_loader.sv
// Instruction-memory program loader: byte stream in, 16-bit words written from
// address 0 up. Optional trailing checksum byte under IMEM_LOADER_CHECKSUM_EN.
module imem_loader
  import imem_pkg::*;
#(
  parameter int ADDR_W = IMEM_ADDR_W,
  parameter int DATA_W = IMEM_DATA_W
)
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load_start,
  input  logic [ADDR_W:0]   load_len,
  input  logic              abort,
  input  logic              in_valid,
  input  logic [7:0]        in_data,
  output logic              in_ready,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [DATA_W-1:0] wr_data,
  output logic              cpu_hold,
  output logic              busy,
  output logic              done,
  output logic              err
);

`ifdef IMEM_LOADER_CHECKSUM_EN
  localparam ldr_state_t END_ST = ST_CHK;
`else
  localparam ldr_state_t END_ST = ST_DONE;
`endif

  ldr_state_t      st, st_nxt;
  logic [ADDR_W:0] cnt;
  logic            byte_acc;
  logic            start_acc;
  logic            last_word;

  assign byte_acc  = in_valid && in_ready && !abort;
  assign start_acc = (st == ST_IDLE) && load_start && !abort;
  assign last_word = (cnt == (ADDR_W+1)'(1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st <= ST_IDLE;
    end else begin
      st <= st_nxt;
    end
  end

  always_comb begin
    st_nxt = st;
    if (abort) begin
      st_nxt = ST_IDLE;
    end else begin
      case (st)
        ST_IDLE:  if (load_start) st_nxt = (load_len == '0) ? END_ST : ST_HI;
        ST_HI:    if (in_valid) st_nxt = ST_LO;
        ST_LO:    if (in_valid) st_nxt = ST_WRITE;
        ST_WRITE: st_nxt = last_word ? END_ST : ST_HI;
        ST_CHK:   if (in_valid) st_nxt = ST_DONE;
        ST_DONE:  st_nxt = ST_IDLE;
        default:  st_nxt = ST_IDLE;
      endcase
    end
  end

  // Every handshake/status output is a pure decode of the state register.
  always_comb begin
    in_ready = 1'b0;
    wr_en    = 1'b0;
    done     = 1'b0;
    cpu_hold = (st != ST_IDLE);
    busy     = (st != ST_IDLE);
    case (st)
      ST_HI, ST_LO, ST_CHK: in_ready = 1'b1;
      ST_WRITE:             wr_en    = 1'b1;
      ST_DONE:              done     = 1'b1;
      default:              ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt     <= '0;
      wr_addr <= '0;
      wr_data <= '0;
    end else if (!abort) begin
      if (start_acc) begin
        cnt     <= load_len;
        wr_addr <= '0;
      end
      if (byte_acc && (st == ST_HI)) wr_data[DATA_W-1 -: 8] <= in_data;
      if (byte_acc && (st == ST_LO)) wr_data[7:0] <= in_data;
      // A full-length load wraps wr_addr back to 0; cnt reaching 0 stops writes.
      if (st == ST_WRITE) begin
        wr_addr <= wr_addr + ADDR_W'(1);
        cnt     <= cnt - (ADDR_W+1)'(1);
      end
    end
  end

`ifdef IMEM_LOADER_CHECKSUM_EN
  logic err_q;
  logic csum_bad;

  imem_loader_csum u_csum (
    .clk       (clk),
    .rst_n     (rst_n),
    .clr       (start_acc),
    .data_vld  (byte_acc && ((st == ST_HI) || (st == ST_LO))),
    .data_byte (in_data),
    .mismatch  (csum_bad)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_q <= 1'b0;
    end else if (start_acc) begin
      err_q <= 1'b0;
    end else if (byte_acc && (st == ST_CHK) && csum_bad) begin
      err_q <= 1'b1;
    end
  end

  assign err = err_q;
`else
  assign err = 1'b0;
`endif

endmodule

// File: tb/tb_imem_loader.sv
// Randomized self-checking bench for imem_loader; expected writes come from a
// queue built directly from the byte stream that is sent.
module tb_imem_loader;

  localparam int AW = 8;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          load_start;
  logic [AW:0]   load_len;
  logic          abort;
  logic          in_valid;
  logic [7:0]    in_data;
  logic          in_ready;
  logic          wr_en;
  logic [AW-1:0] wr_addr;
  logic [15:0]   wr_data;
  logic          cpu_hold;
  logic          busy;
  logic          done;
  logic          err;

  always #5 clk = ~clk;

  imem_loader #(.ADDR_W(AW), .DATA_W(16)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .load_start (load_start),
    .load_len   (load_len),
    .abort      (abort),
    .in_valid   (in_valid),
    .in_data    (in_data),
    .in_ready   (in_ready),
    .wr_en      (wr_en),
    .wr_addr    (wr_addr),
    .wr_data    (wr_data),
    .cpu_hold   (cpu_hold),
    .busy       (busy),
    .done       (done),
    .err        (err)
  );

  typedef struct {
    logic [7:0]  addr;
    logic [15:0] data;
  } wr_t;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int n_wr = 0;
  int n_done = 0;
  int last_wr_cyc = 0;
  int done_cyc = 0;
  wr_t exp_q[$];
  logic [7:0] bq[$];
  logic [15:0] obs_data [256];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // Per-cycle compare against the expected-write queue and output invariants.
  always @(negedge clk) begin
    wr_t e;
    if (rst_n) begin
      if (wr_en) begin
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_write actual=addr %0h data %0h required=no write", wr_addr, wr_data);
        end else begin
          e = exp_q.pop_front();
          chk("wr_addr", 32'(wr_addr), 32'(e.addr));
          chk("wr_data", 32'(wr_data), 32'(e.data));
        end
        obs_data[wr_addr] = wr_data;
        last_wr_cyc = cyc;
        n_wr++;
      end
      if (done) begin
        n_done++;
        done_cyc = cyc;
      end
      chk("ready_during_write", 32'(in_ready & wr_en), 32'd0);
      chk("hold_vs_busy", 32'(cpu_hold), 32'(busy));
      chk("ready_implies_hold", 32'(in_ready & ~cpu_hold), 32'd0);
    end
  end

  task automatic start(input int len);
    @(posedge clk); #1;
    load_start = 1'b1;
    load_len   = 9'(len);
    @(posedge clk); #1;
    load_start = 1'b0;
    load_len   = 9'($urandom);
  endtask

  task automatic send_byte(input logic [7:0] b, input int max_gap, input bit spur);
    int t;
    repeat ($urandom_range(0, max_gap)) begin
      in_valid = 1'b0;
      in_data  = 8'($urandom);
      if (spur && ($urandom_range(0, 7) == 0)) begin
        load_start = 1'b1;
        load_len   = 9'd1;
      end
      @(posedge clk); #1;
      load_start = 1'b0;
    end
    in_valid = 1'b1;
    in_data  = b;
    t = 0;
    while (!in_ready && t < 20) begin
      @(posedge clk); #1;
      t++;
    end
    if (t >= 20) begin
      checks++;
      failures++;
      $display("FAIL byte_timeout actual=in_ready low 20 cycles required=in_ready high");
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic push_words(input int nwords);
    wr_t w;
    for (int i = 0; i < nwords; i++) begin
      w.addr = 8'(i);
      w.data = {bq[2*i], bq[2*i+1]};
      exp_q.push_back(w);
    end
  endtask

  task automatic fill_bq(input int nbytes);
    bq.delete();
    for (int i = 0; i < nbytes; i++) bq.push_back(8'($urandom));
  endtask

  task automatic run_load(input int len, input int max_gap, input bit spur,
                          input bit force_cs, input logic [7:0] cs);
    int pre_done, pre_wr, t;
    logic [7:0] x;
    bit exp_err;
    x = 8'h00;
    for (int i = 0; i < 2*len; i++) x = x ^ bq[i];
    push_words(len);
    pre_done = n_done;
    pre_wr   = n_wr;
    start(len);
    chk("err_cleared_on_start", 32'(err), 32'd0);
`ifdef IMEM_LOADER_CHECKSUM_EN
    chk("first_ready", 32'(in_ready), 32'd1);
`else
    chk("first_ready", 32'(in_ready), 32'(len > 0));
`endif
    for (int i = 0; i < 2*len; i++) send_byte(bq[i], max_gap, spur);
`ifdef IMEM_LOADER_CHECKSUM_EN
    exp_err = force_cs && (cs != x);
    send_byte(force_cs ? cs : x, max_gap, 1'b0);
`else
    exp_err = 1'b0;
`endif
    t = 0;
    while (n_done == pre_done && t < 40) begin
      @(posedge clk);
      t++;
    end
    if (t >= 40) begin
      checks++;
      failures++;
      $display("FAIL done_timeout actual=no done required=done pulse");
    end
    #1;
    chk("done_once", 32'(n_done - pre_done), 32'd1);
    chk("hold_after_done", 32'(cpu_hold), 32'd0);
    chk("busy_after_done", 32'(busy), 32'd0);
    chk("done_one_cycle", 32'(done), 32'd0);
    chk("write_count", 32'(n_wr - pre_wr), 32'(len));
    chk("exp_drained", 32'(exp_q.size()), 32'd0);
    chk("err_result", 32'(err), 32'(exp_err));
    if (len > 0) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
      chk("done_latency_ge2", 32'((done_cyc - last_wr_cyc) >= 2), 32'd1);
`else
      chk("done_latency", 32'(done_cyc - last_wr_cyc), 32'd1);
`endif
    end else begin
      chk("len0_done_fast", 32'(t <= 2 + 2*max_gap + 1), 32'd1);
    end
  endtask

  initial begin
    int pre_done, pre_wr;
    rst_n      = 1'b0;
    load_start = 1'b0;
    load_len   = '0;
    abort      = 1'b0;
    in_valid   = 1'b0;
    in_data    = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_in_ready", 32'(in_ready), 32'd0);
    chk("rst_wr_en", 32'(wr_en), 32'd0);
    chk("rst_wr_addr", 32'(wr_addr), 32'd0);
    chk("rst_wr_data", 32'(wr_data), 32'd0);
    chk("rst_cpu_hold", 32'(cpu_hold), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_err", 32'(err), 32'd0);
    rst_n = 1'b1;

    // Directed two-word load with literal results.
    bq.delete();
    bq.push_back(8'h12); bq.push_back(8'h34); bq.push_back(8'hAB); bq.push_back(8'hCD);
    run_load(2, 0, 1'b0, 1'b0, 8'h00);
    chk("lit_word0", 32'(obs_data[0]), 32'h1234);
    chk("lit_word1", 32'(obs_data[1]), 32'hABCD);

    // Zero-length load.
    bq.delete();
    run_load(0, 0, 1'b0, 1'b0, 8'h00);

`ifdef IMEM_LOADER_CHECKSUM_EN
    bq.delete();
    bq.push_back(8'h12); bq.push_back(8'h34);
    run_load(1, 0, 1'b0, 1'b1, 8'h26);
    chk("lit_csum_ok", 32'(err), 32'd0);
    bq.delete();
    bq.push_back(8'h12); bq.push_back(8'h34);
    run_load(1, 0, 1'b0, 1'b1, 8'h27);
    chk("lit_csum_bad", 32'(err), 32'd1);
    repeat (5) @(posedge clk);
    #1;
    chk("err_sticky", 32'(err), 32'd1);
`endif

    for (int k = 0; k < 4; k++) begin
      fill_bq(18);
      run_load($urandom_range(1, 9), 2, 1'b1, 1'b0, 8'h00);
    end

    fill_bq(512);
    run_load(256, 3, 1'b1, 1'b0, 8'h00);

    // Abort in LO of the second word of a 4-word load.
    fill_bq(8);
    push_words(1);
    pre_done = n_done;
    pre_wr   = n_wr;
    start(4);
    send_byte(bq[0], 0, 1'b0);
    send_byte(bq[1], 0, 1'b0);
    @(posedge clk); #1;
    load_start = 1'b1;
    load_len   = 9'd1;
    @(posedge clk); #1;
    load_start = 1'b0;
    send_byte(bq[2], 0, 1'b0);
    abort = 1'b1;
    @(posedge clk); #1;
    abort = 1'b0;
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_hold", 32'(cpu_hold), 32'd0);
    chk("abort_ready", 32'(in_ready), 32'd0);
    repeat (6) @(posedge clk);
    #1;
    chk("abort_no_done", 32'(n_done - pre_done), 32'd0);
    chk("abort_writes", 32'(n_wr - pre_wr), 32'd1);
    chk("abort_exp_drained", 32'(exp_q.size()), 32'd0);

    // Asynchronous reset while in LO of the second word.
    fill_bq(6);
    push_words(1);
    pre_wr = n_wr;
    start(3);
    send_byte(bq[0], 0, 1'b0);
    send_byte(bq[1], 0, 1'b0);
    send_byte(bq[2], 0, 1'b0);
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_in_ready", 32'(in_ready), 32'd0);
    chk("arst_wr_en", 32'(wr_en), 32'd0);
    chk("arst_wr_addr", 32'(wr_addr), 32'd0);
    chk("arst_wr_data", 32'(wr_data), 32'd0);
    chk("arst_cpu_hold", 32'(cpu_hold), 32'd0);
    chk("arst_busy", 32'(busy), 32'd0);
    chk("arst_done", 32'(done), 32'd0);
    chk("arst_err", 32'(err), 32'd0);
    chk("arst_writes", 32'(n_wr - pre_wr), 32'd1);
    chk("arst_exp_drained", 32'(exp_q.size()), 32'd0);
    exp_q.delete();
    @(posedge clk); #1;
    rst_n = 1'b1;
    bq.delete();
    bq.push_back(8'h55); bq.push_back(8'h66);
    run_load(1, 1, 1'b0, 1'b0, 8'h00);
    chk("lit_after_reset", 32'(obs_data[0]), 32'h5566);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #1000000;
    failures++;
    $display("FAIL watchdog actual=still running required=finished");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
